mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single 32-bit block-wide RAM port. Requester 0 is the instruction-side cache and requester 1 is the data-side cache. The block latches one winning request and drives the RAM load/store handshake (load_req/load_completed; wren/store_completed/store_ack). It returns the 32-bit block or a store-done pulse to the winner. A watchdog terminates hung transactions with an error.

---
 rtl/mem_port_arbiter_if.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM-side bundle for mem_port_arbiter.
// slave = arbiter view, master = environment view.
interface mem_port_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 32
);
   logic          r0_valid;
   logic          r0_we;
   logic [AW-1:0] r0_addr;
   logic [DW-1:0] r0_wdata;
   logic          r0_done;
   logic          r0_err;
   logic [DW-1:0] r0_rdata;

   logic          r1_valid;
   logic          r1_we;
   logic [AW-1:0] r1_addr;
   logic [DW-1:0] r1_wdata;
   logic          r1_done;
   logic          r1_err;
   logic [DW-1:0] r1_rdata;

   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_wren;
   logic          mem_store_ack;
   logic          mem_load_req;
   logic          mem_load_completed;
   logic          mem_store_completed;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  r0_valid, r0_we, r0_addr, r0_wdata,
      output r0_done, r0_err, r0_rdata,
      input  r1_valid, r1_we, r1_addr, r1_wdata,
      output r1_done, r1_err, r1_rdata,
      output mem_addr, mem_wdata, mem_wren,
      output mem_store_ack, mem_load_req,
      input  mem_load_completed, mem_store_completed,
      input  mem_rdata
   );

   modport master (
      output r0_valid, r0_we, r0_addr, r0_wdata,
      input  r0_done, r0_err, r0_rdata,
      output r1_valid, r1_we, r1_addr, r1_wdata,
      input  r1_done, r1_err, r1_rdata,
      input  mem_addr, mem_wdata, mem_wren,
      input  mem_store_ack, mem_load_req,
      output mem_load_completed, mem_store_completed,
      output mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// I/D-cache arbiter and sequencer for the single block-wide RAM port.
// Define ARB_ROUND_ROBIN_EN to alternate tie grants (default: data side wins).
module mem_port_arbiter #(
   parameter int AW      = 16,
   parameter int DW      = 32,
   parameter int TIMEOUT = 64
)(
   input  logic              clk,
   input  logic              rst_n,
   mem_port_arbiter_if.slave bus
);
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD_WAIT,
      S_ST_WAIT,
      S_ST_ACK,
      S_RESP
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_rdata0;
   logic [DW-1:0] r_rdata1;
   logic          r_we;
   logic          r_id;
   logic          r_err;
   logic [CW-1:0] r_wdog;

   logic w_any;
   logic w_gnt;
   logic w_gnt_we;
   logic w_to;
   logic w_abort;
   logic w_ld_cap;
   logic w_wait;

   assign w_any = bus.r0_valid | bus.r1_valid;

`ifdef ARB_ROUND_ROBIN_EN
   logic r_last;
   assign w_gnt = (bus.r0_valid & bus.r1_valid) ? ~r_last
                                                : bus.r1_valid;
`else
   assign w_gnt = bus.r1_valid;
`endif

   assign w_gnt_we = w_gnt ? bus.r1_we : bus.r0_we;
   assign w_to     = (r_wdog == CW'(TIMEOUT - 1));
   assign w_wait   = (r_state == S_LD_WAIT) |
                     (r_state == S_ST_WAIT) |
                     (r_state == S_ST_ACK);

   always_comb begin
      w_next   = r_state;
      w_abort  = 1'b0;
      w_ld_cap = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_any)
               w_next = w_gnt_we ? S_ST_WAIT : S_LD_WAIT;
         end
         S_LD_WAIT: begin
            if (bus.mem_load_completed) begin
               w_next   = S_RESP;
               w_ld_cap = 1'b1;
            end else if (w_to) begin
               w_next  = S_RESP;
               w_abort = 1'b1;
            end
         end
         S_ST_WAIT: begin
            if (bus.mem_store_completed) begin
               w_next = S_ST_ACK;
            end else if (w_to) begin
               w_next  = S_RESP;
               w_abort = 1'b1;
            end
         end
         S_ST_ACK: begin
            if (!bus.mem_store_completed) begin
               w_next = S_RESP;
            end else if (w_to) begin
               w_next  = S_RESP;
               w_abort = 1'b1;
            end
         end
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Watchdog restarts on every state change so each wait phase gets its own budget.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_wdog  <= '0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state)
            r_wdog <= '0;
         else if (w_wait)
            r_wdog <= r_wdog + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr   <= '0;
         r_wdata  <= '0;
         r_we     <= 1'b0;
         r_id     <= 1'b0;
         r_err    <= 1'b0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         r_last   <= 1'b1;
`endif
      end else begin
         if (r_state == S_IDLE && w_any) begin
            r_id    <= w_gnt;
            r_we    <= w_gnt_we;
            r_addr  <= w_gnt ? bus.r1_addr  : bus.r0_addr;
            r_wdata <= w_gnt ? bus.r1_wdata : bus.r0_wdata;
            r_err   <= 1'b0;
         end
         if (w_abort)
            r_err <= 1'b1;
         if (w_ld_cap) begin
            if (r_id)
               r_rdata1 <= bus.mem_rdata;
            else
               r_rdata0 <= bus.mem_rdata;
         end
`ifdef ARB_ROUND_ROBIN_EN
         if (r_state == S_RESP)
            r_last <= r_id;
`endif
      end
   end

   assign bus.mem_addr      = r_addr;
   assign bus.mem_wdata     = r_wdata;
   assign bus.mem_wren      = (r_state == S_ST_WAIT) & r_we;
   assign bus.mem_store_ack = (r_state == S_ST_ACK);
   assign bus.mem_load_req  = (r_state == S_LD_WAIT) & ~r_we;

   assign bus.r0_done  = (r_state == S_RESP) & ~r_id;
   assign bus.r1_done  = (r_state == S_RESP) &  r_id;
   assign bus.r0_err   = bus.r0_done & r_err;
   assign bus.r1_err   = bus.r1_done & r_err;
   assign bus.r0_rdata = r_rdata0;
   assign bus.r1_rdata = r_rdata1;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a small RAM model.
// Expected responses are queued at issue and checked by a monitor.
module tb_mem_port_arbiter;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int TO = 8;

   typedef struct {
      bit          id;
      bit          err;
      logic [31:0] rdata;
      bit          chk;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;
   exp_t q[$];

   logic [31:0] ram [0:255];
   int   ld_cnt;
   int   ld_lat  = 0;
   bit   ld_hang = 1'b0;
   bit   hold_st = 1'b0;
   logic st_c;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus();

   mem_port_arbiter #(
      .AW(AW), .DW(DW), .TIMEOUT(TO)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   assign bus.mem_load_completed  = bus.mem_load_req & ~ld_hang
                                    & (ld_cnt >= ld_lat);
   assign bus.mem_rdata           = ram[bus.mem_addr[7:0]];
   assign bus.mem_store_completed = st_c;

   // RAM model: store completes one cycle after wren, drops after ack.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_c   <= 1'b0;
         ld_cnt <= 0;
         for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
         ram[8'h08] <= 32'hCAFE_BABE;
         ram[8'h10] <= 32'hA5A5_0010;
         ram[8'h30] <= 32'h1111_2222;
         ram[8'h40] <= 32'h3333_4444;
      end else begin
         ld_cnt <= bus.mem_load_req ? ld_cnt + 1 : 0;
         if (bus.mem_wren) begin
            ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
            st_c <= 1'b1;
         end else if (bus.mem_store_ack && !hold_st) begin
            st_c <= 1'b0;
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic push(input bit id, input bit err,
                       input logic [31:0] rd, input bit chk);
      exp_t e;
      e.id = id; e.err = err; e.rdata = rd; e.chk = chk;
      q.push_back(e);
   endtask

   task automatic req(input bit id, input bit we,
                      input logic [15:0] a, input logic [31:0] d);
      if (id) begin
         bus.r1_we = we; bus.r1_addr = a;
         bus.r1_wdata = d; bus.r1_valid = 1'b1;
      end else begin
         bus.r0_we = we; bus.r0_addr = a;
         bus.r0_wdata = d; bus.r0_valid = 1'b1;
      end
   endtask

   task automatic wait_done(input int n);
      int got;
      got = 0;
      for (int c = 0; c < 200 && got < n; c++) begin
         @(negedge clk);
         if (bus.r0_done) begin bus.r0_valid = 1'b0; got++; end
         if (bus.r1_done) begin bus.r1_valid = 1'b0; got++; end
      end
      check("done_count", 32'(got), 32'(n));
   endtask

   initial begin : mon
      bit   prev;
      bit   d0, d1;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         d0 = bus.r0_done;
         d1 = bus.r1_done;
         if (d0 || d1) begin
            check("dual_done", 32'(d0 & d1), 32'd0);
            check("done_pulse", 32'(prev), 32'd0);
            check("sb_pending", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
               e = q.pop_front();
               check("resp_id", 32'(d1), 32'(e.id));
               check("resp_err", 32'(d1 ? bus.r1_err : bus.r0_err),
                     32'(e.err));
               if (e.chk)
                  check("resp_rdata",
                        d1 ? bus.r1_rdata : bus.r0_rdata, e.rdata);
            end
         end
         prev = d0 | d1;
      end
   end

   initial begin : stim
      int  n;
      bit  seen;
      bus.r0_valid = 1'b0; bus.r0_we = 1'b0;
      bus.r0_addr = '0;    bus.r0_wdata = '0;
      bus.r1_valid = 1'b0; bus.r1_we = 1'b0;
      bus.r1_addr = '0;    bus.r1_wdata = '0;

      repeat (2) @(negedge clk);
      check("rst_wren", 32'(bus.mem_wren), 32'd0);
      check("rst_ldreq", 32'(bus.mem_load_req), 32'd0);
      check("rst_ack", 32'(bus.mem_store_ack), 32'd0);
      check("rst_done", 32'({bus.r0_done, bus.r1_done}), 32'd0);
      check("rst_addr", 32'(bus.mem_addr), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      push(1'b0, 1'b0, 32'hCAFE_BABE, 1'b1);
      req(1'b0, 1'b0, 16'h0008, 32'h0);
      @(negedge clk);
      check("ld_req_lat", 32'(bus.mem_load_req), 32'd1);
      wait_done(1);

      @(negedge clk);
      push(1'b1, 1'b0, 32'h0, 1'b0);
      req(1'b1, 1'b1, 16'h0004, 32'h0000_DEAD);
      wait_done(1);
      check("st_ram", ram[8'h04], 32'h0000_DEAD);
      @(negedge clk);
      check("st_ack_low", 32'(bus.mem_store_ack), 32'd0);

      for (int r = 0; r < 4; r++) begin
         @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
         push(1'b0, 1'b0, 32'hA5A5_0010, 1'b1);
         push(1'b1, 1'b0, 32'h0, 1'b0);
`else
         push(1'b1, 1'b0, 32'h0, 1'b0);
         push(1'b0, 1'b0, 32'hA5A5_0010, 1'b1);
`endif
         req(1'b0, 1'b0, 16'h0010, 32'h0);
         req(1'b1, 1'b1, 16'h0020, 32'hBEEF_0000 | 32'(r));
         wait_done(2);
      end
      check("arb_ram", ram[8'h20], 32'hBEEF_0003);

      @(negedge clk);
      ld_lat = 3;
      push(1'b0, 1'b0, 32'h1111_2222, 1'b1);
      req(1'b0, 1'b0, 16'h0030, 32'h0);
      @(negedge clk);
      bus.r0_addr = 16'h0040;
      @(negedge clk);
      check("stable_addr", 32'(bus.mem_addr), 32'h0030);
      wait_done(1);
      ld_lat = 0;

      @(negedge clk);
      ld_hang = 1'b1;
      push(1'b0, 1'b1, 32'h0, 1'b0);
      req(1'b0, 1'b0, 16'h0008, 32'h0);
      n = 0;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         if (bus.mem_load_req) n++;
         if (bus.r0_done) begin bus.r0_valid = 1'b0; seen = 1'b1; end
      end
      check("to_req_cycles", 32'(n), 32'(TO));
      check("to_done_seen", 32'(seen), 32'd1);
      ld_hang = 1'b0;

      @(negedge clk);
      hold_st = 1'b1;
      req(1'b0, 1'b1, 16'h0050, 32'h1234_5678);
      for (int c = 0; c < 20 && !bus.mem_store_ack; c++)
         @(negedge clk);
      check("ack_reached", 32'(bus.mem_store_ack), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_wren", 32'(bus.mem_wren), 32'd0);
      check("mid_rst_ack", 32'(bus.mem_store_ack), 32'd0);
      check("mid_rst_done", 32'({bus.r0_done, bus.r1_done}), 32'd0);
      bus.r0_valid = 1'b0;
      bus.r0_we = 1'b0;
      hold_st = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push(1'b0, 1'b0, 32'hCAFE_BABE, 1'b1);
      req(1'b0, 1'b0, 16'h0008, 32'h0);
      wait_done(1);

      repeat (3) @(negedge clk);
      check("sb_empty", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
